// File: rtl/aes_round_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : aes_round_ctrl
// Description : Round sequencer for the two-share threshold AES core. Steps the
//               shared datapath through LOAD, ten rounds of four column-serial
//               S-box issues + pipeline drain + commit, and a DONE pulse. Drives
//               the rcon block and ends the schedule on its round flags.
//               Optional macro AES_ROUND_CTRL_CNT_CHECK_EN adds an internal
//               round counter that cross-checks the rcon flags. A mismatch
//               raises a sticky fault and aborts the operation.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module aes_round_ctrl #(
   parameter int SBOX_LAT = 4   // shared S-box pipeline latency, 1..7
) (
   input  logic       ClkxCI,
   input  logic       RstxBI,
   input  logic       StartxSI,
   output logic       BusyxSO,
   output logic       DonexSO,
   output logic       RandReqxSO,
   input  logic       RandVldxSI,
   output logic       LoadxSO,
   output logic       SboxEnxSO,
   output logic [1:0] ColSelxDO,
   output logic       CommitxSO,
   output logic       MixColxSO,
   output logic       KeyExpxSO,
   output logic       RconNextxSO,
   output logic       RconActivexSO,
   input  logic       LastRoundxSI,
   input  logic       NineRoundxSI,
   input  logic       FinishedxSI,
   output logic       FaultxSO
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      SUB    = 3'd2,
      DRAIN  = 3'd3,
      COMMIT = 3'd4,
      DONE   = 3'd5
   } stateT;

   // Last value of the drain counter before moving on to COMMIT.
   localparam logic [2:0] DRAIN_LAST = 3'(SBOX_LAT - 1);

   stateT      StatexDP, StatexDN;
   logic [1:0] ColCntxDP, ColCntxDN;
   logic [2:0] DrainCntxDP, DrainCntxDN;

   logic       faultxS;    // sticky fault, blocks new operations
   logic       chkErrxS;   // rcon flags disagree with our own round count

`ifdef AES_ROUND_CTRL_CNT_CHECK_EN
   logic [3:0] RoundCntxDP, RoundCntxDN;
   logic       FaultxDP, FaultxDN;

   // Compare the rcon round flags against the internal round count.
   always_comb begin
      chkErrxS = 1'b0;
      unique case (StatexDP)
         SUB, DRAIN, COMMIT: begin
            chkErrxS = (NineRoundxSI != (RoundCntxDP == 4'd9))  ||
                       (LastRoundxSI != (RoundCntxDP == 4'd10)) ||
                       FinishedxSI;
         end
         IDLE:    chkErrxS = ~FinishedxSI;
         default: chkErrxS = 1'b0;
      endcase
   end

   // Round counter follows the rcon schedule: 1 on LOAD, +1 per inner commit.
   always_comb begin
      RoundCntxDN = RoundCntxDP;
      FaultxDN    = FaultxDP | chkErrxS;
      if (StatexDP == LOAD) begin
         RoundCntxDN = 4'd1;
      end else if ((StatexDP == COMMIT) && !LastRoundxSI) begin
         RoundCntxDN = RoundCntxDP + 4'd1;
      end
   end

   // Checker state registers; the fault only clears on reset.
   always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) begin
         RoundCntxDP <= 4'd0;
         FaultxDP    <= 1'b0;
      end else begin
         RoundCntxDP <= RoundCntxDN;
         FaultxDP    <= FaultxDN;
      end
   end

   assign faultxS  = FaultxDP;
   assign FaultxSO = FaultxDP;
`else
   // Without the checker the rcon flags are trusted and the nine-round flag
   // has no consumer.
   logic unusedNinexS;

   assign unusedNinexS = NineRoundxSI;
   assign chkErrxS     = 1'b0;
   assign faultxS      = 1'b0;
   assign FaultxSO     = 1'b0;
`endif

   // State and counter registers.
   always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) begin
         StatexDP    <= IDLE;
         ColCntxDP   <= 2'd0;
         DrainCntxDP <= 3'd0;
      end else begin
         StatexDP    <= StatexDN;
         ColCntxDP   <= ColCntxDN;
         DrainCntxDP <= DrainCntxDN;
      end
   end

   // Next-state logic and state-decoded outputs.
   always_comb begin
      StatexDN      = StatexDP;
      ColCntxDN     = ColCntxDP;
      DrainCntxDN   = DrainCntxDP;
      BusyxSO       = 1'b1;
      DonexSO       = 1'b0;
      RandReqxSO    = 1'b0;
      LoadxSO       = 1'b0;
      SboxEnxSO     = 1'b0;
      ColSelxDO     = 2'd0;
      CommitxSO     = 1'b0;
      MixColxSO     = 1'b0;
      KeyExpxSO     = 1'b0;
      RconNextxSO   = 1'b0;
      RconActivexSO = 1'b0;

      unique case (StatexDP)
         IDLE: begin
            BusyxSO = 1'b0;
            // A start while rcon is mid-schedule (or after a fault) is dropped.
            if (StartxSI && FinishedxSI && !faultxS) begin
               StatexDN = LOAD;
            end
         end

         LOAD: begin
            LoadxSO     = 1'b1;
            RconNextxSO = 1'b1;
            ColCntxDN   = 2'd0;
            StatexDN    = SUB;
         end

         SUB: begin
            RandReqxSO = 1'b1;
            ColSelxDO  = ColCntxDP;
            // A column only issues when a fresh mask is available; otherwise
            // everything holds for as long as the PRNG needs.
            SboxEnxSO  = RandVldxSI;
            if (RandVldxSI) begin
               ColCntxDN = ColCntxDP + 2'd1;
               if (ColCntxDP == 2'd3) begin
                  DrainCntxDN = 3'd0;
                  StatexDN    = DRAIN;
               end
            end
         end

         DRAIN: begin
            if (DrainCntxDP == DRAIN_LAST) begin
               StatexDN = COMMIT;
            end else begin
               DrainCntxDN = DrainCntxDP + 3'd1;
            end
         end

         COMMIT: begin
            CommitxSO     = 1'b1;
            KeyExpxSO     = 1'b1;
            RconActivexSO = 1'b1;
            RconNextxSO   = 1'b1;
            // The final round skips MixColumns.
            MixColxSO     = ~LastRoundxSI;
            if (LastRoundxSI) begin
               StatexDN = DONE;
            end else begin
               ColCntxDN = 2'd0;
               StatexDN  = SUB;
            end
         end

         DONE: begin
            DonexSO  = 1'b1;
            StatexDN = IDLE;
         end

         default: begin
            StatexDN = IDLE;
         end
      endcase

      // A flag mismatch aborts the operation; DONE is never reached.
      if (chkErrxS) begin
         StatexDN = IDLE;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_aes_round_ctrl
// Description : Self-checking bench for aes_round_ctrl. Two instances
//               (SBOX_LAT=4 and SBOX_LAT=1) each with a behavioural rcon model.
//               Table-driven full runs plus hand sequences for reset
//               mid-operation and forced round flags.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_aes_round_ctrl;

   logic ClkxCI = 1'b0;
   always #5 ClkxCI = ~ClkxCI;

   logic RstxBI      = 1'b0;
   logic StartAxS    = 1'b0;
   logic StartBxS    = 1'b0;
   logic RandVldxS   = 1'b0;
   logic ForceLastxS = 1'b0;
   logic selB        = 1'b0;

   // Instance A: SBOX_LAT = 4
   logic BusyA, DoneA, ReqA, LoadA, SboxA, CommitA, MixA, KeyA, NextA, ActA, FaultA;
   logic [1:0] ColA;
   logic [7:0] RconA;
   logic LastA, NineA, FinA;
   // Instance B: SBOX_LAT = 1
   logic BusyB, DoneB, ReqB, LoadB, SboxB, CommitB, MixB, KeyB, NextB, ActB, FaultB;
   logic [1:0] ColB;
   logic [7:0] RconB;
   logic LastB, NineB, FinB;

   aes_round_ctrl #(.SBOX_LAT(4)) dutA (
      .ClkxCI(ClkxCI), .RstxBI(RstxBI), .StartxSI(StartAxS), .BusyxSO(BusyA),
      .DonexSO(DoneA), .RandReqxSO(ReqA), .RandVldxSI(RandVldxS), .LoadxSO(LoadA),
      .SboxEnxSO(SboxA), .ColSelxDO(ColA), .CommitxSO(CommitA), .MixColxSO(MixA),
      .KeyExpxSO(KeyA), .RconNextxSO(NextA), .RconActivexSO(ActA),
      .LastRoundxSI(LastA), .NineRoundxSI(NineA), .FinishedxSI(FinA), .FaultxSO(FaultA));

   aes_round_ctrl #(.SBOX_LAT(1)) dutB (
      .ClkxCI(ClkxCI), .RstxBI(RstxBI), .StartxSI(StartBxS), .BusyxSO(BusyB),
      .DonexSO(DoneB), .RandReqxSO(ReqB), .RandVldxSI(RandVldxS), .LoadxSO(LoadB),
      .SboxEnxSO(SboxB), .ColSelxDO(ColB), .CommitxSO(CommitB), .MixColxSO(MixB),
      .KeyExpxSO(KeyB), .RconNextxSO(NextB), .RconActivexSO(ActB),
      .LastRoundxSI(LastB), .NineRoundxSI(NineB), .FinishedxSI(FinB), .FaultxSO(FaultB));

   // Behavioural rcon: 6C -> 01 -> xtime ... -> 36 -> 6C.
   function automatic logic [7:0] rconStep(input logic [7:0] r);
      if (r == 8'h6C) return 8'h01;
      if (r == 8'h36) return 8'h6C;
      return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
   endfunction

   always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) RconA <= 8'h6C;
      else if (NextA) RconA <= rconStep(RconA);
   end
   always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) RconB <= 8'h6C;
      else if (NextB) RconB <= rconStep(RconB);
   end

   assign LastA = (RconA == 8'h36) | ForceLastxS;
   assign NineA = (RconA == 8'h1B);
   assign FinA  = (RconA == 8'h6C);
   assign LastB = (RconB == 8'h36);
   assign NineB = (RconB == 8'h1B);
   assign FinB  = (RconB == 8'h6C);

   // Selected-instance view used by the table-driven runs.
   logic sBusy, sDone, sReq, sLoad, sSbox, sCommit, sMix, sKey, sNext, sAct, sFault;
   logic [1:0] sCol;
   logic [7:0] sRcon;
   assign sBusy   = selB ? BusyB   : BusyA;
   assign sDone   = selB ? DoneB   : DoneA;
   assign sReq    = selB ? ReqB    : ReqA;
   assign sLoad   = selB ? LoadB   : LoadA;
   assign sSbox   = selB ? SboxB   : SboxA;
   assign sCommit = selB ? CommitB : CommitA;
   assign sMix    = selB ? MixB    : MixA;
   assign sKey    = selB ? KeyB    : KeyA;
   assign sNext   = selB ? NextB   : NextA;
   assign sAct    = selB ? ActB    : ActA;
   assign sFault  = selB ? FaultB  : FaultA;
   assign sCol    = selB ? ColB    : ColA;
   assign sRcon   = selB ? RconB   : RconA;

   int nChk = 0;
   int nErr = 0;

   task automatic check(input string nm, input int act, input int exp);
      nChk++;
      if (act != exp) begin
         nErr++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   typedef struct {
      bit useB;     // 0: SBOX_LAT=4 instance, 1: SBOX_LAT=1 instance
      int stRound;  // round (1..10) holding the stall, 0 = none
      int stCol;    // column at which the stall happens
      int stLen;    // stall length in cycles
      bit hold;     // keep StartxSI high throughout
      int expLat;   // cycles from the start cycle to the DONE cycle
   } vecT;

   vecT vecs[6];
   logic [7:0] expRcon[10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                               8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

   task automatic doReset();
      RstxBI = 1'b0; StartAxS = 1'b0; StartBxS = 1'b0;
      RandVldxS = 1'b0; ForceLastxS = 1'b0;
      repeat (2) @(negedge ClkxCI);
      RstxBI = 1'b1;
      @(negedge ClkxCI);
   endtask

   // One complete operation; t=0 is the cycle in which StartxSI is presented.
   task automatic runOp(input vecT v, input int idx);
      int doneAt = -1, dones = 0, commits = 0, loads = 0, sboxes = 0;
      int stalled = 0, mixBad = 0, rconBad = 0, stallBad = 0, faults = 0;
      int busyAfter = -1, loadAfter = -1, rconAtDone = -1;
      string tag;
      tag = $sformatf("v%0d", idx);
      selB = v.useB;
      for (int t = 0; t < 400; t++) begin
         if (v.useB) StartBxS = (t == 0) || v.hold;
         else        StartAxS = (t == 0) || v.hold;
         RandVldxS = 1'b1;
         if (sReq && (commits == v.stRound - 1) && (sCol == 2'(v.stCol)) && (stalled < v.stLen)) begin
            RandVldxS = 1'b0;
            stalled++;
            #1;
            if ((sCol != 2'(v.stCol)) || sSbox || !sReq) stallBad++;
         end else begin
            #1;
         end
         if (sLoad)  loads++;
         if (sSbox)  sboxes++;
         if (sFault) faults++;
         if (sCommit) begin
            commits++;
            if (commits > 10 || sRcon != expRcon[commits-1] || !sKey || !sAct || !sNext) rconBad++;
            if (sMix != (commits != 10)) mixBad++;
         end
         if (sDone) begin
            dones++;
            if (doneAt < 0) begin
               doneAt = t;
               rconAtDone = int'(sRcon);
               if (!sBusy) stallBad++;
            end
         end
         if (doneAt >= 0 && t == doneAt + 1) busyAfter = int'(sBusy);
         if (doneAt >= 0 && t == doneAt + 2) begin
            loadAfter = int'(sLoad);
            break;
         end
         @(negedge ClkxCI);
      end
      StartAxS = 1'b0; StartBxS = 1'b0;
      check({tag, " latency"},        doneAt,     v.expLat);
      check({tag, " done_pulses"},    dones,      1);
      check({tag, " commits"},        commits,    10);
      check({tag, " loads"},          loads,      1 + int'(v.hold));
      check({tag, " sbox_issues"},    sboxes,     40);
      check({tag, " commit_rcon"},    rconBad,    0);
      check({tag, " mixcol"},         mixBad,     0);
      check({tag, " stall_cycles"},   stalled,    v.stLen);
      check({tag, " stall_outputs"},  stallBad,   0);
      check({tag, " rcon_end"},       rconAtDone, 'h6C);
      check({tag, " busy_after"},     busyAfter,  0);
      check({tag, " load_after"},     loadAfter,  int'(v.hold));
      check({tag, " fault"},          faults,     0);
   endtask

   initial begin
      int cnt, found, doneSeen, busyCnt, loadCnt, faultCnt;
      vecs[0] = '{1'b0, 0,  0, 0, 1'b0, 92};
      vecs[1] = '{1'b0, 5,  2, 3, 1'b0, 95};
      vecs[2] = '{1'b1, 0,  0, 0, 1'b0, 62};
      vecs[3] = '{1'b0, 0,  0, 0, 1'b1, 92};
      vecs[4] = '{1'b1, 1,  0, 1, 1'b0, 63};
      vecs[5] = '{1'b0, 10, 3, 4, 1'b0, 96};

      // Reset state while reset is held.
      RstxBI = 1'b0;
      repeat (2) @(negedge ClkxCI);
      check("reset_outs_A", int'({BusyA, DoneA, ReqA, LoadA, SboxA, ColA, CommitA, MixA,
                                  KeyA, NextA, ActA, FaultA}), 0);
      check("reset_outs_B", int'({BusyB, DoneB, ReqB, LoadB, SboxB, ColB, CommitB, MixB,
                                  KeyB, NextB, ActB, FaultB}), 0);
      check("reset_rcon", int'(RconA), 'h6C);

      for (int i = 0; i < 6; i++) begin
         doReset();
         runOp(vecs[i], i);
      end

      // Reset asserted during the round-6 drain.
      doReset();
      selB = 1'b0;
      RandVldxS = 1'b1;
      StartAxS = 1'b1;
      @(negedge ClkxCI);
      StartAxS = 1'b0;
      cnt = 0; found = 0;
      for (int t = 0; t < 200; t++) begin
         if (CommitA) cnt++;
         if (cnt == 5 && BusyA && !ReqA && !CommitA && !LoadA) begin
            found = 1;
            break;
         end
         @(negedge ClkxCI);
      end
      check("mid_drain_found", found, 1);
      #2 RstxBI = 1'b0;
      #1;
      check("mid_reset_outs", int'({BusyA, DoneA, ReqA, LoadA, SboxA, ColA, CommitA, MixA,
                                    KeyA, NextA, ActA, FaultA}), 0);
      check("mid_reset_rcon", int'(RconA), 'h6C);
      @(negedge ClkxCI);
      RstxBI = 1'b1;
      @(negedge ClkxCI);
      runOp(vecs[0], 6);

      // Forced LastRound flag during round 4.
      doReset();
      RandVldxS = 1'b1;
      StartAxS = 1'b1;
      @(negedge ClkxCI);
      StartAxS = 1'b0;
      cnt = 0; found = 0; doneSeen = 0;
`ifdef AES_ROUND_CTRL_CNT_CHECK_EN
      for (int t = 0; t < 200; t++) begin
         if (CommitA) cnt++;
         if (cnt == 3 && ReqA) begin
            ForceLastxS = 1'b1;
            found = 1;
            #1;
            check("fault_not_yet", int'(FaultA), 0);
            break;
         end
         @(negedge ClkxCI);
      end
      check("force_found", found, 1);
      @(negedge ClkxCI);
      check("fault_set", int'(FaultA), 1);
      check("fault_busy", int'(BusyA), 0);
      ForceLastxS = 1'b0;
      busyCnt = 0; loadCnt = 0; faultCnt = 0;
      for (int t = 0; t < 20; t++) begin
         StartAxS = 1'b1;
         @(negedge ClkxCI);
         if (BusyA)  busyCnt++;
         if (LoadA || DoneA) loadCnt++;
         if (FaultA) faultCnt++;
      end
      StartAxS = 1'b0;
      check("fault_start_busy", busyCnt, 0);
      check("fault_no_load_done", loadCnt, 0);
      check("fault_sticky", faultCnt, 20);
      doReset();
      check("fault_cleared", int'(FaultA), 0);
`else
      for (int t = 0; t < 200; t++) begin
         if (CommitA) cnt++;
         if (cnt == 3 && ReqA) ForceLastxS = 1'b1;
         if (FaultA) found++;
         if (DoneA) begin
            doneSeen = 1;
            break;
         end
         @(negedge ClkxCI);
      end
      check("trust_done_seen", doneSeen, 1);
      check("trust_commits", cnt, 4);
      check("trust_no_fault", found, 0);
      ForceLastxS = 1'b0;
      @(negedge ClkxCI);
      check("trust_rcon", int'(RconA), 'h10);
      busyCnt = 0;
      for (int t = 0; t < 10; t++) begin
         StartAxS = 1'b1;
         @(negedge ClkxCI);
         if (BusyA) busyCnt++;
      end
      StartAxS = 1'b0;
      check("trust_start_ignored", busyCnt, 0);
      doReset();
`endif

      $display("Result: errors=%0d of %0d checks", nErr, nChk);
      $finish;
   end

endmodule
`default_nettype wire
